// File: rtl/cu_fetch_unit.sv
// Instruction fetch unit: sequential word fetches with several requests in flight,
// a prefetch FIFO towards decode, and redirect with in-flight response dropping.
module cu_fetch_unit #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       boot_addr_i,
    input  logic              fetch_en_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              fetch_req,
    input  logic              fetch_gnt,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [DATA_W-1:0] fetch_r_data,
    input  logic              fetch_r_valid,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_data_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_ready_i,
    output logic              busy_o,
    output logic              dbg_state
);

    // Handshakes: a request transfers on clk edges with fetch_req && fetch_gnt, and
    // fetch_req/fetch_addr hold until then; the decode port transfers on
    // instr_valid_o && instr_ready_i, and the head is stable while not accepted.

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] WORD   = ADDR_W'(4);
    localparam logic [PTR_W-1:0]  PTR_1  = PTR_W'(1);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q, rsp_pc_q, stale_addr_q, redir_addr;
    logic              stale_q;
    logic [CNT_W-1:0]  out_cnt, drop_cnt, fifo_cnt;
    logic [CNT_W-1:0]  out_next, drop_next, fifo_next;
    logic [CNT_W:0]    credit_sum;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic              gnt_fire, push, pop, drop_rsp, can_issue;
    logic              unused_bits;

    assign unused_bits = ^{boot_addr_i, redirect_addr_i[1:0]};
    assign redir_addr  = {redirect_addr_i[ADDR_W-1:2], 2'b00};

    assign fetch_req  = (state_q == REQ);
    // A request caught by a redirect keeps its old address until it is granted.
    assign fetch_addr = stale_q ? stale_addr_q : pc_q;
    assign gnt_fire   = fetch_req && fetch_gnt;
    assign drop_rsp   = fetch_r_valid && (redirect_valid_i || drop_cnt != '0);
    assign push       = fetch_r_valid && !drop_rsp;

    assign instr_valid_o = (fifo_cnt != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_data_o  = instr_valid_o ? data_mem[rd_ptr] : '0;
    assign instr_addr_o  = instr_valid_o ? addr_mem[rd_ptr] : '0;
    assign busy_o        = fetch_req || (out_cnt != '0);
    assign dbg_state     = state_q;

    always_comb begin
        out_next  = out_cnt;
        drop_next = drop_cnt;
        fifo_next = fifo_cnt;
        state_d   = state_q;
        if (gnt_fire)      out_next = out_next + ONE;
        if (fetch_r_valid) out_next = out_next - ONE;
        if (redirect_valid_i) begin
            fifo_next = '0;
            drop_next = out_next;
        end else begin
            if (push)                 fifo_next = fifo_next + ONE;
            if (pop)                  fifo_next = fifo_next - ONE;
            if (drop_rsp)             drop_next = drop_next - ONE;
            if (gnt_fire && stale_q)  drop_next = drop_next + ONE;
        end
        // Credits count post-update values so issue never overruns the FIFO.
        credit_sum = {1'b0, out_next} + {1'b0, fifo_next};
        can_issue  = fetch_en_i && (credit_sum < (CNT_W+1)'(FIFO_DEPTH))
                     && (out_next < CNT_W'(MAX_OUT));
        case (state_q)
            IDLE:    if (can_issue) state_d = REQ;
            REQ:     if (gnt_fire && !can_issue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= boot_addr_i[ADDR_W-1:0];
            rsp_pc_q     <= boot_addr_i[ADDR_W-1:0];
            stale_q      <= 1'b0;
            stale_addr_q <= '0;
            out_cnt      <= '0;
            drop_cnt     <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state_q  <= state_d;
            out_cnt  <= out_next;
            drop_cnt <= drop_next;
            fifo_cnt <= fifo_next;
            if (redirect_valid_i) begin
                pc_q     <= redir_addr;
                rsp_pc_q <= redir_addr;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                if (fetch_req && !fetch_gnt) begin
                    stale_q <= 1'b1;
                    if (!stale_q) stale_addr_q <= pc_q;
                end else begin
                    stale_q <= 1'b0;
                end
            end else begin
                if (gnt_fire) begin
                    if (stale_q) stale_q <= 1'b0;
                    else         pc_q    <= pc_q + WORD;
                end
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + WORD;
                    wr_ptr   <= wr_ptr + PTR_1;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= rsp_pc_q;
            data_mem[wr_ptr] <= fetch_r_data;
        end
    end

endmodule

// File: tb/tb_cu_fetch_unit.sv
// Directed bench for cu_fetch_unit: stream, reset, wrap, backpressure, redirect cases.
module tb_cu_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] boot_addr_i;
  logic        fetch_en_i;
  logic        redirect_valid_i;
  logic [18:0] redirect_addr_i;
  logic        fetch_req;
  logic        fetch_gnt;
  logic [18:0] fetch_addr;
  logic [31:0] fetch_r_data;
  logic        fetch_r_valid;
  logic        instr_valid_o;
  logic [31:0] instr_data_o;
  logic [18:0] instr_addr_o;
  logic        instr_ready_i;
  logic        busy_o;
  logic        dbg_state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cu_fetch_unit dut (
    .clk(clk), .rst(rst), .boot_addr_i(boot_addr_i), .fetch_en_i(fetch_en_i),
    .redirect_valid_i(redirect_valid_i), .redirect_addr_i(redirect_addr_i),
    .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_addr(fetch_addr),
    .fetch_r_data(fetch_r_data), .fetch_r_valid(fetch_r_valid),
    .instr_valid_o(instr_valid_o), .instr_data_o(instr_data_o),
    .instr_addr_o(instr_addr_o), .instr_ready_i(instr_ready_i),
    .busy_o(busy_o), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory model: the word at address a holds 0xD0000000 + a.
  task automatic rsp(input logic [31:0] a);
    fetch_r_valid = 1'b1;
    fetch_r_data  = 32'hD000_0000 + a;
  endtask

  task automatic no_rsp();
    fetch_r_valid = 1'b0;
    fetch_r_data  = 32'h0;
  endtask

  initial begin
    rst = 1'b1; boot_addr_i = 32'h100; fetch_en_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_addr_i = '0;
    fetch_gnt = 1'b0; instr_ready_i = 1'b0; no_rsp();
    tick(); tick();
    chk("rst_req", fetch_req, 0);
    chk("rst_addr", fetch_addr, 32'h100);
    chk("rst_ivalid", instr_valid_o, 0);
    chk("rst_idata", instr_data_o, 0);
    chk("rst_iaddr", instr_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_state", dbg_state, 0);

    // Basic stream: gnt always, responses two cycles after grant, ready high.
    rst = 1'b0; fetch_en_i = 1'b1; fetch_gnt = 1'b1; instr_ready_i = 1'b1;
    tick();
    chk("bs_req0", fetch_req, 1);
    chk("bs_addr0", fetch_addr, 32'h100);
    tick();
    chk("bs_addr1", fetch_addr, 32'h104);
    tick();
    chk("bs_max_out", fetch_req, 0);
    rsp(32'h100);
    tick();
    chk("bs_req2", fetch_req, 1);
    chk("bs_addr2", fetch_addr, 32'h108);
    chk("bs_iv0", instr_valid_o, 1);
    chk("bs_ia0", instr_addr_o, 32'h100);
    chk("bs_id0", instr_data_o, 32'hD000_0100);
    rsp(32'h104);
    tick();
    chk("bs_ia1", instr_addr_o, 32'h104);
    chk("bs_id1", instr_data_o, 32'hD000_0104);
    chk("bs_addr3", fetch_addr, 32'h10C);
    no_rsp();
    tick();
    chk("bs_req_idle", fetch_req, 0);
    chk("bs_iv_empty", instr_valid_o, 0);
    rsp(32'h108);
    tick();
    chk("bs_ia2", instr_addr_o, 32'h108);
    chk("bs_addr4", fetch_addr, 32'h110);
    instr_ready_i = 1'b0; rsp(32'h10C);
    tick();
    chk("bs_hold_head", instr_addr_o, 32'h108);
    chk("bs_addr5", fetch_addr, 32'h114);
    no_rsp();
    tick();
    chk("bs_req_off", fetch_req, 0);
    chk("bs_busy", busy_o, 1);

    // Reset mid-stream with two outstanding; new boot address near the top.
    rst = 1'b1; boot_addr_i = 32'h7FFFC;
    tick();
    chk("mr_req", fetch_req, 0);
    chk("mr_addr", fetch_addr, 32'h7FFFC);
    chk("mr_ivalid", instr_valid_o, 0);
    chk("mr_idata", instr_data_o, 0);
    chk("mr_iaddr", instr_addr_o, 0);
    chk("mr_busy", busy_o, 0);

    // Wrap-around, then backpressure with ready low.
    rst = 1'b0;
    tick();
    chk("wr_req", fetch_req, 1);
    chk("wr_addr0", fetch_addr, 32'h7FFFC);
    tick();
    chk("wr_addr1", fetch_addr, 32'h0);
    tick();
    chk("bp_req_off0", fetch_req, 0);
    rsp(32'h7FFFC);
    tick();
    chk("bp_req1", fetch_req, 1);
    chk("bp_addr1", fetch_addr, 32'h4);
    chk("wr_ia", instr_addr_o, 32'h7FFFC);
    chk("wr_id", instr_data_o, 32'hD007_FFFC);
    rsp(32'h0);
    tick();
    chk("bp_addr2", fetch_addr, 32'h8);
    no_rsp();
    tick();
    chk("bp_req_off1", fetch_req, 0);
    rsp(32'h4);
    tick();
    rsp(32'h8);
    tick();
    no_rsp();
    chk("bp_full_req", fetch_req, 0);
    chk("bp_full_busy", busy_o, 0);
    chk("bp_full_head", instr_addr_o, 32'h7FFFC);
    tick();
    chk("bp_still_off", fetch_req, 0);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("bp_one_req", fetch_req, 1);
    chk("bp_one_addr", fetch_addr, 32'hC);
    chk("bp_pop_head", instr_addr_o, 32'h0);
    tick();
    chk("bp_one_only", fetch_req, 0);

    // Redirect with one outstanding and one ungranted request.
    rst = 1'b1; boot_addr_i = 32'h100;
    tick();
    rst = 1'b0;
    tick();
    chk("rd_addr0", fetch_addr, 32'h100);
    tick();
    tick();
    chk("rd_idle", fetch_req, 0);
    fetch_gnt = 1'b0; rsp(32'h100);
    tick();
    chk("rd_pend_req", fetch_req, 1);
    chk("rd_pend_addr", fetch_addr, 32'h108);
    chk("rd_pre_head", instr_addr_o, 32'h100);
    no_rsp(); redirect_valid_i = 1'b1; redirect_addr_i = 19'h203;
    tick();
    redirect_valid_i = 1'b0;
    chk("rd_hold_req", fetch_req, 1);
    chk("rd_hold_addr", fetch_addr, 32'h108);
    chk("rd_flushed", instr_valid_o, 0);
    chk("rd_busy", busy_o, 1);
    rsp(32'h104);
    tick();
    chk("rd_hold_addr2", fetch_addr, 32'h108);
    chk("rd_drop1", instr_valid_o, 0);
    no_rsp(); fetch_gnt = 1'b1;
    tick();
    chk("rd_new0", fetch_addr, 32'h200);
    rsp(32'h108);
    tick();
    chk("rd_new1", fetch_addr, 32'h204);
    chk("rd_drop2", instr_valid_o, 0);
    fetch_gnt = 1'b0; rsp(32'h200);
    tick();
    chk("rd_first_v", instr_valid_o, 1);
    chk("rd_first_a", instr_addr_o, 32'h200);
    chk("rd_first_d", instr_data_o, 32'hD000_0200);

    // Redirect coinciding with a response and a grant.
    no_rsp(); fetch_gnt = 1'b1;
    tick();
    chk("rc_addr", fetch_addr, 32'h208);
    rsp(32'h204); redirect_valid_i = 1'b1; redirect_addr_i = 19'h300;
    tick();
    redirect_valid_i = 1'b0; fetch_gnt = 1'b0;
    chk("rc_empty", instr_valid_o, 0);
    chk("rc_addr_new", fetch_addr, 32'h300);
    chk("rc_busy", busy_o, 1);
    rsp(32'h208);
    tick();
    chk("rc_drop_late", instr_valid_o, 0);
    no_rsp(); fetch_gnt = 1'b1;
    tick();
    chk("rc_next_addr", fetch_addr, 32'h304);
    fetch_gnt = 1'b0; rsp(32'h300);
    tick();
    no_rsp();
    chk("rc_first_v", instr_valid_o, 1);
    chk("rc_first_a", instr_addr_o, 32'h300);
    chk("rc_first_d", instr_data_o, 32'hD000_0300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
